// File: rtl/decode_stage_pipelined_pkg.sv
// Shared constants, control-word layout and opcode classification for the LEGv8 decode stage.
package decode_stage_pipelined_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;
    localparam int NUM_REGS  = 32;

    localparam logic [4:0] XZR = 5'(NUM_REGS - 1);

    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
    localparam logic [7:0]  OP_CBNZ = 8'b1011_0101;
    localparam logic [5:0]  OP_B    = 6'b00_0101;

    // Bit order matches out_ctrl: branch is bit 9, alu_op occupies bits 1:0.
    typedef struct packed {
        logic       branch;
        logic       cbz;
        logic       cbnz;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_LOAD,
        CLS_STORE,
        CLS_CBZ,
        CLS_CBNZ,
        CLS_B
    } instr_cls_e;

    // B and CB opcodes are shorter than 11 bits, so match them on their prefix first.
    function automatic instr_cls_e classify(input logic [10:0] op);
        instr_cls_e cls;
        cls = CLS_NONE;
        if (op[10:5] == OP_B)
            cls = CLS_B;
        else if (op[10:3] == OP_CBZ)
            cls = CLS_CBZ;
        else if (op[10:3] == OP_CBNZ)
            cls = CLS_CBNZ;
        else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
            cls = CLS_R;
        else if (op == OP_LDUR)
            cls = CLS_LOAD;
        else if (op == OP_STUR)
            cls = CLS_STORE;
        return cls;
    endfunction

endpackage

// File: rtl/decode_stage_pipelined_if.sv
// Fetch, writeback and ID/EX handshake bundle; slave is the decode stage's view, master the surroundings'.
interface decode_stage_pipelined_if;
    import decode_stage_pipelined_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_LEN-1:0] in_instr;
    logic [WORD-1:0]      in_pc;
    logic                 flush;
    logic                 wb_en;
    logic [4:0]           wb_reg;
    logic [WORD-1:0]      wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD-1:0]      out_pc;
    logic [WORD-1:0]      out_rn_data;
    logic [WORD-1:0]      out_rm_data;
    logic [WORD-1:0]      out_imm;
    logic [10:0]          out_opcode;
    logic [4:0]           out_rd;
    logic [9:0]           out_ctrl;

    modport master (
        output in_valid, in_instr, in_pc, flush, wb_en, wb_reg, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_rn_data, out_rm_data, out_imm,
               out_opcode, out_rd, out_ctrl
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, wb_en, wb_reg, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_rn_data, out_rm_data, out_imm,
               out_opcode, out_rd, out_ctrl
    );

endinterface

// File: rtl/decode_stage_pipelined_regfile.sv
// 2-read/1-write register file with hardwired zero register; same-cycle write-to-read
// forwarding only when DECODE_WB_BYPASS_EN is defined. Array contents are not reset.
module decode_stage_pipelined_regfile
    import decode_stage_pipelined_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int DEPTH = NUM_REGS,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr_a,
    input  logic [AW-1:0]    i_rd_addr_b,
    output logic [WIDTH-1:0] o_rd_data_a,
    output logic [WIDTH-1:0] o_rd_data_b
);
    localparam logic [AW-1:0] ZR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_byp_a;
    logic             w_byp_b;

    always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_addr != ZR)
            r_mem[i_wr_addr] <= i_wr_data;
    end

`ifdef DECODE_WB_BYPASS_EN
    assign w_byp_a = i_wr_en && (i_wr_addr == i_rd_addr_a);
    assign w_byp_b = i_wr_en && (i_wr_addr == i_rd_addr_b);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    assign o_rd_data_a = (i_rd_addr_a == ZR) ? '0 : (w_byp_a ? i_wr_data : r_mem[i_rd_addr_a]);
    assign o_rd_data_b = (i_rd_addr_b == ZR) ? '0 : (w_byp_b ? i_wr_data : r_mem[i_rd_addr_b]);

endmodule

// File: rtl/decode_stage_pipelined.sv
// Pipelined LEGv8 decode stage: parse, register read, control, immediate and ID/EX register
// with valid/ready, flush and load-use interlock. DECODE_WB_BYPASS_EN selects wb forwarding.
module decode_stage_pipelined
    import decode_stage_pipelined_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    decode_stage_pipelined_if.slave io_dec
);
    logic [10:0]     w_opcode;
    logic [4:0]      w_rn;
    logic [4:0]      w_rm;
    logic [4:0]      w_rd;
    logic [4:0]      w_rr2;
    instr_cls_e      w_cls;
    ctrl_t           w_ctrl;
    logic [WORD-1:0] w_imm;
    logic [WORD-1:0] w_rn_data;
    logic [WORD-1:0] w_rr2_data;
    logic            w_free;
    logic            w_lu_hazard;
    logic            w_wb_hazard;
    logic            w_in_ready;
    logic            w_accept;

    logic            r_out_valid;
    logic [WORD-1:0] r_pc;
    logic [WORD-1:0] r_rn_data;
    logic [WORD-1:0] r_rm_data;
    logic [WORD-1:0] r_imm;
    logic [10:0]     r_opcode;
    logic [4:0]      r_rd;
    ctrl_t           r_ctrl;

    assign w_opcode = io_dec.in_instr[31:21];
    assign w_rm     = io_dec.in_instr[20:16];
    assign w_rn     = io_dec.in_instr[9:5];
    assign w_rd     = io_dec.in_instr[4:0];
    assign w_cls    = classify(w_opcode);
    // Stores and compare-branches read their Rt through the second port.
    assign w_rr2    = (w_cls == CLS_STORE || w_cls == CLS_CBZ || w_cls == CLS_CBNZ) ? w_rd : w_rm;

    always_comb begin
        w_ctrl = '0;
        w_imm  = '0;
        case (w_cls)
            CLS_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = 2'b10;
            end
            CLS_LOAD: begin
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_imm = {{(WORD-9){io_dec.in_instr[20]}}, io_dec.in_instr[20:12]};
            end
            CLS_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm = {{(WORD-9){io_dec.in_instr[20]}}, io_dec.in_instr[20:12]};
            end
            CLS_CBZ, CLS_CBNZ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.cbz    = (w_cls == CLS_CBZ);
                w_ctrl.cbnz   = (w_cls == CLS_CBNZ);
                w_ctrl.alu_op = 2'b01;
                w_imm = {{(WORD-19){io_dec.in_instr[23]}}, io_dec.in_instr[23:5]};
            end
            CLS_B: begin
                w_ctrl.branch = 1'b1;
                w_imm = {{(WORD-26){io_dec.in_instr[25]}}, io_dec.in_instr[25:0]};
            end
            default: ;
        endcase
    end

    decode_stage_pipelined_regfile #(
        .WIDTH (WORD),
        .DEPTH (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .i_wr_en     (io_dec.wb_en),
        .i_wr_addr   (io_dec.wb_reg),
        .i_wr_data   (io_dec.wb_data),
        .i_rd_addr_a (w_rn),
        .i_rd_addr_b (w_rr2),
        .o_rd_data_a (w_rn_data),
        .o_rd_data_b (w_rr2_data)
    );

    assign w_lu_hazard = r_out_valid && r_ctrl.mem_read && (r_rd != XZR) && io_dec.in_valid &&
                         ((r_rd == w_rn) || (r_rd == w_rr2));

`ifdef DECODE_WB_BYPASS_EN
    assign w_wb_hazard = 1'b0;
`else
    // Without forwarding, wait one cycle so the array holds the written value.
    assign w_wb_hazard = io_dec.wb_en && (io_dec.wb_reg != XZR) && io_dec.in_valid &&
                         ((io_dec.wb_reg == w_rn) || (io_dec.wb_reg == w_rr2));
`endif

    assign w_free     = !r_out_valid || io_dec.out_ready;
    assign w_in_ready = rst_n && w_free && !w_lu_hazard && !w_wb_hazard && !io_dec.flush;
    assign w_accept   = io_dec.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_rn_data   <= '0;
            r_rm_data   <= '0;
            r_imm       <= '0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_ctrl      <= '0;
        end else if (io_dec.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= io_dec.in_pc;
            r_rn_data   <= w_rn_data;
            r_rm_data   <= w_rr2_data;
            r_imm       <= w_imm;
            r_opcode    <= w_opcode;
            r_rd        <= w_rd;
            r_ctrl      <= w_ctrl;
        end else if (w_free) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_dec.in_ready    = w_in_ready;
    assign io_dec.out_valid   = r_out_valid;
    assign io_dec.out_pc      = r_pc;
    assign io_dec.out_rn_data = r_rn_data;
    assign io_dec.out_rm_data = r_rm_data;
    assign io_dec.out_imm     = r_imm;
    assign io_dec.out_opcode  = r_opcode;
    assign io_dec.out_rd      = r_rd;
    assign io_dec.out_ctrl    = r_ctrl;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: expected ID/EX contents are queued on accept
// and compared when execute consumes them; directed checks cover stalls, flush and reset.
module tb_decode_stage_pipelined;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [7:0]  T_CBZ  = 8'b10110100;
    localparam logic [7:0]  T_CBNZ = 8'b10110101;

    localparam logic [9:0] C_R    = 10'h006;
    localparam logic [9:0] C_LDUR = 10'h06C;
    localparam logic [9:0] C_STUR = 10'h018;
    localparam logic [9:0] C_CBZ  = 10'h301;
    localparam logic [9:0] C_CBNZ = 10'h281;
    localparam logic [9:0] C_B    = 10'h200;

`ifdef DECODE_WB_BYPASS_EN
    localparam int WB_STALL = 0;
`else
    localparam int WB_STALL = 1;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [63:0] rn;
        logic [63:0] rm;
        logic [63:0] imm;
        logic [10:0] op;
        logic [4:0]  rd;
        logic [9:0]  ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_bubble = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [63:0] mregs [32];
    logic [4:0]  cur_rs1;
    logic [4:0]  cur_rs2;
    logic [9:0]  cur_ctrl;
    logic [63:0] cur_imm;
    int          st;

    always #5 clk = ~clk;

    decode_stage_pipelined_if dif ();

    decode_stage_pipelined dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_dec (dif)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] a,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {op, a, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] a,
                                           input logic [4:0] rt);
        return {op, a, rt};
    endfunction

    function automatic logic [31:0] enc_b(input logic [25:0] a);
        return {6'b000101, a};
    endfunction

    function automatic logic [63:0] model_rd(input logic [4:0] r);
        if (r == 5'd31)
            return 64'd0;
        if (dif.wb_en && dif.wb_reg == r)
            return dif.wb_data;
        return mregs[r];
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] instr, input logic [63:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [9:0] ctrl, input logic [63:0] imm);
        cur_rs1       = rs1;
        cur_rs2       = rs2;
        cur_ctrl      = ctrl;
        cur_imm       = imm;
        dif.in_instr  = instr;
        dif.in_pc     = pc;
        dif.in_valid  = 1'b1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [63:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [9:0] ctrl, input logic [63:0] imm,
                        output int stalls);
        bit done;
        set_instr(instr, pc, rs1, rs2, ctrl, imm);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (dif.in_ready) done = 1'b1;
            else stalls++;
            sync();
            dif.wb_en = 1'b0;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        dif.in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
        dif.wb_en   = 1'b1;
        dif.wb_reg  = r;
        dif.wb_data = d;
        sync();
        dif.wb_en   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!dif.out_valid) n_bubble++;
            if (dif.out_valid && (dif.flush || dif.out_ready)) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (!dif.flush) begin
                        chk("out_pc",   dif.out_pc, mon_e.pc);
                        chk("out_rn",   dif.out_rn_data, mon_e.rn);
                        chk("out_rm",   dif.out_rm_data, mon_e.rm);
                        chk("out_imm",  dif.out_imm, mon_e.imm);
                        chk("out_op",   64'(dif.out_opcode), 64'(mon_e.op));
                        chk("out_rd",   64'(dif.out_rd), 64'(mon_e.rd));
                        chk("out_ctrl", 64'(dif.out_ctrl), 64'(mon_e.ctrl));
                    end
                end
            end
            if (dif.in_valid && dif.in_ready) begin
                mon_e.pc   = dif.in_pc;
                mon_e.rn   = model_rd(cur_rs1);
                mon_e.rm   = model_rd(cur_rs2);
                mon_e.imm  = cur_imm;
                mon_e.op   = dif.in_instr[31:21];
                mon_e.rd   = dif.in_instr[4:0];
                mon_e.ctrl = cur_ctrl;
                sb_q.push_back(mon_e);
            end
            if (dif.wb_en && dif.wb_reg != 5'd31)
                mregs[dif.wb_reg] = dif.wb_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.in_pc     = '0;
        dif.flush     = 1'b0;
        dif.wb_en     = 1'b0;
        dif.wb_reg    = '0;
        dif.wb_data   = '0;
        dif.out_ready = 1'b1;
        cur_rs1 = '0; cur_rs2 = '0; cur_ctrl = '0; cur_imm = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(dif.out_valid), 64'd0);
        chk("rst_in_ready",  64'(dif.in_ready), 64'd0);
        chk("rst_out_ctrl",  64'(dif.out_ctrl), 64'd0);
        chk("rst_out_pc",    dif.out_pc, 64'd0);
        sync();
        rst_n = 1'b1;

        for (int r = 0; r < 31; r++) wb_write(5'(r), 64'h1000 + 64'(r));
        wb_write(5'd1, 64'd100);
        wb_write(5'd2, 64'd5);
        wb_write(5'd3, 64'd7);

        // ADD X1,X2,X3 and one-cycle latency
        send(enc_r(T_ADD, 5'd3, 5'd2, 5'd1), 64'h100, 5'd2, 5'd3, C_R, 64'd0, st);
        chk("add_stall", 64'(st), 64'd0);
        @(negedge clk);
        chk("add_latency", 64'(dif.out_valid), 64'd1);
        sync();

        send(enc_r(T_SUB, 5'd2, 5'd1, 5'd10), 64'h104, 5'd1, 5'd2, C_R, 64'd0, st);
        send(enc_r(T_AND, 5'd2, 5'd3, 5'd11), 64'h108, 5'd3, 5'd2, C_R, 64'd0, st);
        chk("thru_and", 64'(st), 64'd0);
        send(enc_r(T_ORR, 5'd3, 5'd1, 5'd12), 64'h10C, 5'd1, 5'd3, C_R, 64'd0, st);
        chk("thru_orr", 64'(st), 64'd0);

        // load-use on rn
        send(enc_d(T_LDUR, 9'd8, 5'd2, 5'd4), 64'h200, 5'd2, 5'd0, C_LDUR, 64'd8, st);
        chk("ldur_stall", 64'(st), 64'd0);
        n_bubble = 0;
        send(enc_r(T_ADD, 5'd1, 5'd4, 5'd5), 64'h204, 5'd4, 5'd1, C_R, 64'd0, st);
        chk("lu_stall", 64'(st), 64'd1);
        chk("lu_bubble", 64'(n_bubble), 64'd1);

        // load-use through the store's Rt port
        send(enc_d(T_LDUR, 9'd16, 5'd2, 5'd8), 64'h208, 5'd2, 5'd1, C_LDUR, 64'd16, st);
        send(enc_d(T_STUR, 9'd0, 5'd3, 5'd8), 64'h20C, 5'd3, 5'd8, C_STUR, 64'd0, st);
        chk("lu_rt_stall", 64'(st), 64'd1);

        // load to XZR never interlocks
        send(enc_d(T_LDUR, 9'h1F8, 5'd2, 5'd31), 64'h210, 5'd2, 5'd31, C_LDUR,
             64'hFFFF_FFFF_FFFF_FFF8, st);
        send(enc_r(T_ADD, 5'd31, 5'd31, 5'd9), 64'h214, 5'd31, 5'd31, C_R, 64'd0, st);
        chk("lu_xzr_stall", 64'(st), 64'd0);

        // backpressure
        send(enc_r(T_ADD, 5'd3, 5'd2, 5'd13), 64'h300, 5'd2, 5'd3, C_R, 64'd0, st);
        dif.out_ready = 1'b0;
        set_instr(enc_r(T_ORR, 5'd2, 5'd1, 5'd14), 64'h304, 5'd1, 5'd2, C_R, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(dif.in_ready), 64'd0);
            chk("bp_out_valid", 64'(dif.out_valid), 64'd1);
            chk("bp_out_pc", dif.out_pc, 64'h300);
            chk("bp_out_rd", 64'(dif.out_rd), 64'd13);
            sync();
        end
        dif.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 64'(dif.in_ready), 64'd1);
        sync();
        dif.in_valid = 1'b0;

        // flush kills the ID/EX entry and blocks the accept; wb still lands
        send(enc_r(T_ADD, 5'd3, 5'd2, 5'd15), 64'h400, 5'd2, 5'd3, C_R, 64'd0, st);
        set_instr(enc_r(T_SUB, 5'd3, 5'd2, 5'd16), 64'h404, 5'd2, 5'd3, C_R, 64'd0);
        dif.flush   = 1'b1;
        dif.wb_en   = 1'b1;
        dif.wb_reg  = 5'd7;
        dif.wb_data = 64'h77;
        @(negedge clk);
        chk("flush_in_ready", 64'(dif.in_ready), 64'd0);
        sync();
        dif.flush    = 1'b0;
        dif.in_valid = 1'b0;
        dif.wb_en    = 1'b0;
        @(negedge clk);
        chk("flush_kill", 64'(dif.out_valid), 64'd0);
        sync();
        send(enc_r(T_ADD, 5'd3, 5'd7, 5'd17), 64'h408, 5'd7, 5'd3, C_R, 64'd0, st);

        // writeback racing a store's Rt read
        dif.wb_en   = 1'b1;
        dif.wb_reg  = 5'd6;
        dif.wb_data = 64'hDEAD;
        send(enc_d(T_STUR, 9'd0, 5'd2, 5'd6), 64'h500, 5'd2, 5'd6, C_STUR, 64'd0, st);
        chk("wb_same_cycle_stall", 64'(st), 64'(WB_STALL));

        // XZR write ignored; branches, immediates, unknown opcode
        wb_write(5'd31, 64'h1234);
        send(enc_cb(T_CBZ, 19'h7FFFC, 5'd31), 64'h504, 5'd28, 5'd31, C_CBZ,
             64'hFFFF_FFFF_FFFF_FFFC, st);
        send(enc_cb(T_CBNZ, 19'd5, 5'd6), 64'h508, 5'd5, 5'd6, C_CBNZ, 64'd5, st);
        send(enc_b(26'h2000000), 64'h50C, 5'd0, 5'd0, C_B, 64'hFFFF_FFFF_FE00_0000, st);
        send(enc_b(26'h0000123), 64'h510, 5'd9, 5'd0, C_B, 64'h123, st);
        send(32'h0000_0C41, 64'h514, 5'd2, 5'd0, 10'd0, 64'd0, st);

        // reset while the output register is full
        send(enc_r(T_ADD, 5'd3, 5'd2, 5'd18), 64'h600, 5'd2, 5'd3, C_R, 64'd0, st);
        dif.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(dif.out_valid), 64'd0);
        chk("mrst_out_ctrl", 64'(dif.out_ctrl), 64'd0);
        chk("mrst_in_ready", 64'(dif.in_ready), 64'd0);
        sb_q.delete();
        dif.out_ready = 1'b1;
        sync();
        sync();
        #2;
        rst_n = 1'b1;
        sync();
        send(enc_r(T_ADD, 5'd3, 5'd2, 5'd1), 64'h700, 5'd2, 5'd3, C_R, 64'd0, st);
        chk("post_rst_stall", 64'(st), 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
